// File: rtl/somador_subtrator_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : somador_subtrator_pkg                                  |
// | Purpose  : Shared opcodes and default width for the add/sub unit  |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
package somador_subtrator_pkg;

  localparam logic OP_ADD        = 1'b1;
  localparam logic OP_SUB        = 1'b0;
  localparam int   DEFAULT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/somador_subtrator_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : somador_subtrator_if                                   |
// | Purpose  : Operand/result bundle; flags exist only when           |
// |            SOMADOR_SUBTRATOR_FLAGS_EN is defined                  |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
interface somador_subtrator_if
  import somador_subtrator_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
);

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         select;
  logic         in_valid;
  logic [N:0]   resul;
  logic         out_valid;
`ifdef SOMADOR_SUBTRATOR_FLAGS_EN
  logic         zero;
  logic         neg;
  logic         carry;

  modport master (output a, b, select, in_valid,
                  input  resul, out_valid, zero, neg, carry);
  modport slave  (input  a, b, select, in_valid,
                  output resul, out_valid, zero, neg, carry);
`else
  modport master (output a, b, select, in_valid,
                  input  resul, out_valid);
  modport slave  (input  a, b, select, in_valid,
                  output resul, out_valid);
`endif

endinterface
`default_nettype wire

// File: rtl/somador_subtrator_sync_completo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : somador_completo                                       |
// | Purpose  : 1-bit full adder, one cell of the ripple chain         |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
module somador_completo (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule
`default_nettype wire

// File: rtl/somador_subtrator_sync.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : somador_subtrator_sync                                 |
// | Purpose  : Registered N-bit unsigned add/sub, (N+1)-bit result.   |
// |            Optional flags: SOMADOR_SUBTRATOR_FLAGS_EN             |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
module somador_subtrator_sync
  import somador_subtrator_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  wire logic          clock,
  input  wire logic          reset,
  somador_subtrator_if.slave bus
);

  localparam int C_W = N + 1;

  logic           w_invert_b;
  logic [C_W-1:0] w_a_ext;
  logic [C_W-1:0] w_b_ext;
  logic [C_W-1:0] w_sum;
  logic [N:0]     w_carry;
  logic           w_unused_cout;

  logic [C_W-1:0] r_resul;
  logic           r_out_valid;

  // Subtract is a + ~b + 1: invert the zero-extended b and inject a carry-in.
  assign w_invert_b = (bus.select == OP_SUB);
  assign w_a_ext    = {1'b0, bus.a};
  assign w_b_ext    = {1'b0, bus.b} ^ {C_W{w_invert_b}};
  assign w_carry[0] = w_invert_b;

  for (genvar i = 0; i <= N; i++) begin : g_ripple
    if (i < N) begin : g_mid
      somador_completo u_fa (
        .a    (w_a_ext[i]),
        .b    (w_b_ext[i]),
        .cin  (w_carry[i]),
        .s    (w_sum[i]),
        .cout (w_carry[i+1])
      );
    end else begin : g_msb
      // Carry out of the extended bit carries no information beyond w_sum[N].
      somador_completo u_fa (
        .a    (w_a_ext[i]),
        .b    (w_b_ext[i]),
        .cin  (w_carry[i]),
        .s    (w_sum[i]),
        .cout (w_unused_cout)
      );
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_resul     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_resul <= w_sum;
      end
    end
  end

  assign bus.resul     = r_resul;
  assign bus.out_valid = r_out_valid;

`ifdef SOMADOR_SUBTRATOR_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_carry;

  // The MSB is a borrow for subtract and a carry-out for add.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
    end else if (bus.in_valid) begin
      r_zero  <= (w_sum == '0);
      r_neg   <= (bus.select == OP_SUB) & w_sum[N];
      r_carry <= (bus.select == OP_ADD) & w_sum[N];
    end
  end

  assign bus.zero  = r_zero;
  assign bus.neg   = r_neg;
  assign bus.carry = r_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_somador_subtrator_sync.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : tb_somador_subtrator_sync                              |
// | Purpose  : Scoreboard bench for somador_subtrator_sync, N=4       |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_somador_subtrator_sync;

  localparam int N = 4;

  typedef struct {
    logic [N:0] r;
    logic       z;
    logic       n;
    logic       c;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  somador_subtrator_if #(.N(N)) bus ();

  somador_subtrator_sync #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clock) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("resul", int'(bus.resul), int'(e.r));
`ifdef SOMADOR_SUBTRATOR_FLAGS_EN
        check("zero",  int'(bus.zero),  int'(e.z));
        check("neg",   int'(bus.neg),   int'(e.n));
        check("carry", int'(bus.carry), int'(e.c));
`endif
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sel, input logic [N:0] er);
    exp_t e;
    e.r = er;
    e.z = (er == '0);
    e.n = !sel && (a < b);
    e.c = sel && er[N];
    q.push_back(e);
  endtask

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic sel, input logic [N:0] er);
    @(negedge clock);
    bus.a        = a;
    bus.b        = b;
    bus.select   = sel;
    bus.in_valid = 1'b1;
    push_exp(a, b, sel, er);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a        = '0;
    bus.b        = '0;
    bus.select   = 1'b1;
    bus.in_valid = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_resul", int'(bus.resul), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
`ifdef SOMADOR_SUBTRATOR_FLAGS_EN
    check("reset_flags", int'({bus.zero, bus.neg, bus.carry}), 0);
`endif
    reset = 1'b0;

    op(4'd0,  4'd0, 1'b1, 5'd0);
    op(4'd1,  4'd0, 1'b1, 5'd1);
    op(4'd1,  4'd2, 1'b1, 5'd3);
    op(4'd3,  4'd1, 1'b1, 5'd4);
    op(4'd15, 4'd15, 1'b1, 5'd30);
    op(4'd15, 4'd1, 1'b1, 5'd16);
    op(4'd3,  4'd1, 1'b0, 5'd2);
    op(4'd1,  4'd1, 1'b0, 5'd0);
    op(4'd4,  4'd1, 1'b0, 5'd3);
    op(4'd0,  4'd1, 1'b0, 5'b11111);
    op(4'd1,  4'd2, 1'b0, 5'b11111);
    idle();

    // Back-to-back stream, then a gap: result must hold its last value.
    op(4'd3, 4'd1, 1'b1, 5'd4);
    op(4'd3, 4'd1, 1'b0, 5'd2);
    op(4'd1, 4'd1, 1'b0, 5'd0);
    idle();
    @(negedge clock);
    check("gap_out_valid", int'(bus.out_valid), 0);
    check("gap_resul_hold", int'(bus.resul), 0);

    // Reset on the same edge as a valid operation discards it.
    op(4'd2, 4'd3, 1'b1, 5'd5);
    @(negedge clock);
    reset        = 1'b1;
    bus.a        = 4'd7;
    bus.b        = 4'd7;
    bus.select   = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clock);
    check("midreset_resul", int'(bus.resul), 0);
    check("midreset_out_valid", int'(bus.out_valid), 0);
    reset = 1'b0;
    push_exp(4'd7, 4'd7, 1'b1, 5'd14);

    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          int m;
          m = (s == 1) ? (x + y) : (x - y);
          op(N'(x), N'(y), s[0], 5'(m & 31));
        end
      end
    end
    idle();

    repeat (3) @(negedge clock);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
